// File: rtl/mux16_sched_pkg.sv
// Shared definitions for the 16-requester round-robin mux scheduler.
//   N_REQ         : number of requesters / mux inputs
//   SEL_W         : width of the mux select bus
//   CNT_W         : width of the per-grant beat counter
//   sched_state_e : scheduler FSM states (IDLE arbitration, GRANT ownership)
package mux16_sched_pkg;

  localparam int N_REQ = 16;
  localparam int SEL_W = 4;
  localparam int CNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } sched_state_e;

endpackage

// File: rtl/rr_pick16.sv
// Combinational round-robin picker: returns the first set request at or
// above ptr, wrapping from 15 to 0.
// Ports:
//   req   [15:0] in  : request vector
//   ptr   [3:0]  in  : highest-priority index for this pick
//   found        out : at least one request is set
//   idx   [3:0]  out : winning requester index (valid when found)
module rr_pick16
  import mux16_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [N_REQ-1:0] rot;
  logic [SEL_W-1:0] off;

  // Rotate right by ptr so the priority position lands at bit 0; the low
  // half of the doubled vector is exactly that rotation.
  assign rot = N_REQ'({req, req} >> ptr);

  // Find-first-set from bit 0: iterate downward so the lowest set bit wins.
  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = SEL_W'(i);
      end
    end
  end

  // Undo the rotation; the 4-bit add wraps modulo 16.
  assign idx = off + ptr;

endmodule

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler for a shared 16:1 data mux. Grants one requester at
// a time, drives the mux select and a one-hot grant, and holds the grant
// until the owner drops its request or MAX_HOLD beats have been acked.
// Ports:
//   clk          in  : clock, rising edge
//   rst_n        in  : synchronous active-low reset
//   req   [15:0] in  : level-sensitive requests
//   ack_in       in  : downstream consumed the current beat this cycle
//   sel   [3:0]  out : mux select (current/last owner), registered
//   gnt   [15:0] out : one-hot grant, zero when no owner, registered
//   busy         out : high while a grant is held (mirrors FSM state GRANT)
//
// Handshake: req[i] is a level that stays high for as long as requester i
// wants the mux. gnt[i] high means the mux output carries requester i's data
// from that cycle on; each cycle with gnt != 0 and ack_in = 1 is one
// transferred beat. Dropping req[i] ends the grant at the next edge. ack_in
// while gnt == 0 carries no meaning and is ignored.
module mux16_rr_sched
  import mux16_sched_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             ack_in,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] gnt,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_HOLD - 1);

  sched_state_e     state, state_d;
  logic [SEL_W-1:0] ptr, ptr_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [SEL_W-1:0] sel_d;
  logic [N_REQ-1:0] gnt_d;
  logic             busy_d;

  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             rel;

  rr_pick16 u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Release when the owner lets go, or when this ack is its last allowed beat.
  assign rel = !req[sel] || (ack_in && (cnt == LAST_BEAT));

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    cnt_d   = cnt;
    sel_d   = sel;
    gnt_d   = gnt;
    busy_d  = busy;
    case (state)
      IDLE: begin
        if (pick_found) begin
          sel_d   = pick_idx;
          gnt_d   = N_REQ'(1) << pick_idx;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (rel) begin
          // sel is deliberately left at the old owner so the mux select
          // does not move during the bubble cycle.
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = sel + SEL_W'(1);
          state_d = IDLE;
        end else if (ack_in) begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
      sel   <= '0;
      gnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      cnt   <= cnt_d;
      sel   <= sel_d;
      gnt   <= gnt_d;
      busy  <= busy_d;
    end
  end

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Bench for mux16_rr_sched: two instances (MAX_HOLD = 8 and MAX_HOLD = 1)
// share stimulus. A grant-level model (owner index, beats used, next
// priority) predicts every cycle's outputs into an expected queue that a
// negedge process compares; directed phases add literal expectations.
module tb_mux16_rr_sched;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        ack_in;

  logic [3:0]  sel_a  [2];
  logic [15:0] gnt_a  [2];
  logic        busy_a [2];

  int mh [2] = '{8, 1};

  int checks = 0;
  int errors = 0;

  // model: owner < 0 means nobody holds the mux
  int m_owner [2];
  int m_ptr   [2];
  int m_beats [2];
  int m_last  [2];

  logic [20:0] exp_q[$];

  mux16_rr_sched #(.MAX_HOLD(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .ack_in(ack_in),
    .sel(sel_a[0]), .gnt(gnt_a[0]), .busy(busy_a[0])
  );

  mux16_rr_sched #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .ack_in(ack_in),
    .sel(sel_a[1]), .gnt(gnt_a[1]), .busy(busy_a[1])
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_owner[k] = -1;
        m_ptr[k]   = 0;
        m_beats[k] = 0;
        m_last[k]  = 0;
      end else if (m_owner[k] < 0) begin
        for (int j = 0; j < 16; j++) begin
          int c;
          c = (m_ptr[k] + j) % 16;
          if (m_owner[k] < 0 && req[c]) m_owner[k] = c;
        end
        m_beats[k] = 0;
      end else begin
        if (!req[m_owner[k]] || (ack_in && (m_beats[k] + 1 == mh[k]))) begin
          m_last[k]  = m_owner[k];
          m_ptr[k]   = (m_owner[k] + 1) % 16;
          m_owner[k] = -1;
        end else if (ack_in) begin
          m_beats[k] = m_beats[k] + 1;
        end
      end
      if (m_owner[k] >= 0)
        exp_q.push_back({1'b1, 4'(m_owner[k]), 16'(1) << m_owner[k]});
      else
        exp_q.push_back({1'b0, 4'(m_last[k]), 16'h0000});
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (exp_q.size() >= 2) begin
      for (int k = 0; k < 2; k++) begin
        logic [20:0] e;
        e = exp_q.pop_front();
        check($sformatf("sb_gnt%0d", k),  32'(gnt_a[k]),  32'(e[15:0]));
        check($sformatf("sb_sel%0d", k),  32'(sel_a[k]),  32'(e[19:16]));
        check($sformatf("sb_busy%0d", k), 32'(busy_a[k]), 32'(e[20]));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cycle(input logic [15:0] r, input logic a);
    req    = r;
    ack_in = a;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle(16'h0000, 1'b0);
    rst_n = 1'b1;
  endtask

  logic [15:0] rnd_req;

  initial begin
    rst_n  = 1'b0;
    req    = '0;
    ack_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // idle after reset
    check("rst_gnt", 32'(gnt_a[0]), 32'h0);
    check("rst_sel", 32'(sel_a[0]), 32'h0);
    check("rst_busy", 32'(busy_a[0]), 32'h0);
    for (int i = 0; i < 5; i++) begin
      cycle(16'h0000, 1'b0);
      check("idle_gnt", 32'(gnt_a[0]), 32'h0);
      check("idle_busy", 32'(busy_a[0]), 32'h0);
    end

    // single requester 5, eight beats then bubble then re-grant
    cycle(16'h0020, 1'b1);
    check("single_gnt", 32'(gnt_a[0]), 32'h0020);
    check("single_sel", 32'(sel_a[0]), 32'd5);
    check("single_busy", 32'(busy_a[0]), 32'h1);
    repeat (7) cycle(16'h0020, 1'b1);
    check("single_held", 32'(gnt_a[0]), 32'h0020);
    cycle(16'h0020, 1'b1);
    check("single_release", 32'(gnt_a[0]), 32'h0);
    check("single_sel_kept", 32'(sel_a[0]), 32'd5);
    cycle(16'h0020, 1'b1);
    check("single_regrant", 32'(gnt_a[0]), 32'h0020);
    cycle(16'h0000, 1'b0);

    // all requesting: rotation 0..15,0 with 8-cycle grants and 1 bubble
    do_reset();
    for (int k = 0; k < 17; k++) begin
      int w;
      int h;
      w = 0;
      while (gnt_a[0] == 16'h0 && w < 4) begin
        cycle(16'hFFFF, 1'b1);
        w++;
      end
      check("rot_bubble", 32'(w), 32'd1);
      check("rot_owner", 32'(sel_a[0]), 32'(k % 16));
      h = 0;
      while (gnt_a[0] != 16'h0 && h < 20) begin
        cycle(16'hFFFF, 1'b1);
        h++;
      end
      check("rot_len", 32'(h), 32'd8);
    end
    cycle(16'h0000, 1'b0);
    cycle(16'h0000, 1'b0);

    // early drop of owner 3 with 9 and 2 pending; next pick starts at 4
    do_reset();
    cycle(16'h0208, 1'b0);
    check("drop_sel", 32'(sel_a[0]), 32'd3);
    check("drop_gnt", 32'(gnt_a[0]), 32'h0008);
    cycle(16'h0208, 1'b0);
    cycle(16'h0204, 1'b0);
    check("drop_release", 32'(gnt_a[0]), 32'h0);
    cycle(16'h0204, 1'b0);
    check("drop_next_gnt", 32'(gnt_a[0]), 32'h0200);
    check("drop_next_sel", 32'(sel_a[0]), 32'd9);
    cycle(16'h0000, 1'b0);

    // owner 15: request drop coincides with the 8th ack
    do_reset();
    cycle(16'h8000, 1'b1);
    check("wrap_gnt", 32'(gnt_a[0]), 32'h8000);
    repeat (7) cycle(16'h8001, 1'b1);
    check("wrap_held", 32'(gnt_a[0]), 32'h8000);
    cycle(16'h0001, 1'b1);
    check("wrap_release", 32'(gnt_a[0]), 32'h0);
    check("wrap_sel_kept", 32'(sel_a[0]), 32'd15);
    cycle(16'h0001, 1'b0);
    check("wrap_next_gnt", 32'(gnt_a[0]), 32'h0001);
    check("wrap_next_sel", 32'(sel_a[0]), 32'd0);
    cycle(16'h0000, 1'b0);

    // move priority to 5, grant 7, reset mid-grant
    cycle(16'h0010, 1'b0);
    cycle(16'h0000, 1'b0);
    cycle(16'h0080, 1'b0);
    check("mid_gnt", 32'(gnt_a[0]), 32'h0080);
    rst_n = 1'b0;
    cycle(16'h0084, 1'b0);
    check("mid_rst_gnt", 32'(gnt_a[0]), 32'h0);
    check("mid_rst_sel", 32'(sel_a[0]), 32'h0);
    check("mid_rst_busy", 32'(busy_a[0]), 32'h0);
    rst_n = 1'b1;
    cycle(16'h0084, 1'b0);
    check("post_rst_gnt", 32'(gnt_a[0]), 32'h0004);
    check("post_rst_sel", 32'(sel_a[0]), 32'd2);

    // randomized traffic, checked by the model every cycle
    rnd_req = '0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 4) == 0) rnd_req = '0;
        else rnd_req = 16'($urandom) & 16'($urandom);
      end
      rst_n = ($urandom_range(0, 199) != 0);
      cycle(rnd_req, 1'($urandom_range(0, 2) != 0));
    end
    rst_n = 1'b1;
    cycle(16'h0000, 1'b0);
    cycle(16'h0000, 1'b0);
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux16_rr_sched.md
# mux16_rr_sched

Round-robin scheduler that shares a 16:1 data multiplexer among 16 requesters. It drives the mux select bus and a one-hot grant vector, and holds each grant until the owner drops its request or a beat budget is spent. It sits in the parent directly beside the `mux_16x1` instance. Its `sel` output connects to the mux `si` input; the mux output feeds a single downstream consumer that acknowledges each beat.

## Interface
Parameters:
- `MAX_HOLD`, default 8: maximum acknowledged beats per grant; legal range 1..255.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req` input 16: request from requester i; level-sensitive.
- `ack_in` input 1: downstream consumed the current mux output beat this cycle.
- `sel` output 4: mux select, index of the current owner; registered.
- `gnt` output 16: one-hot grant; all zero when there is no owner; registered.
- `busy` output 1: high while in GRANT; registered.

## Operation
- Two states: IDLE and GRANT. Internal registers:
  - `ptr` (4 bits): next-priority index.
  - `cnt` (8 bits): beats acknowledged in the current grant.
- IDLE:
  - If `req` is nonzero, pick the first set bit scanning upward from `ptr`, wrapping 15 to 0.
  - Load `sel` with the winner index and set `gnt[winner]`.
  - Set `busy`, clear `cnt`, and go to GRANT.
  - If `req` is zero, stay in IDLE with all outputs unchanged (`gnt` = 0).
- GRANT: outputs are held stable. Release occurs when either:
  - (a) `req[sel]` is 0, or
  - (b) `ack_in` is 1 and `cnt` equals MAX_HOLD-1.
- On release:
  - `gnt` is cleared, `busy` is cleared, and the state returns to IDLE.
  - `ptr` becomes `sel`+1 mod 16; 15 wraps to 0.
  - `sel` keeps its last value.
- Otherwise, `cnt` increments on each cycle with `ack_in` = 1.
- `ack_in` is ignored in IDLE.
- (a) and (b) in the same cycle: a single release, with the `ptr` update as above.
- Requests from non-owners have no effect during GRANT. They are only considered at the next IDLE cycle.
- With MAX_HOLD = 1, every acknowledged beat releases the grant.
- `sel` always equals the index of the set `gnt` bit whenever `gnt` is nonzero.

## Timing
- Reset values: `sel` = 0, `gnt` = 0, `busy` = 0, `ptr` = 0, `cnt` = 0, state IDLE.
- Reset mid-grant: all outputs return to reset values on the next edge. No partial release and no `ptr` advance.
- Grant latency: a request seen in IDLE at edge n produces `gnt` and `sel` valid after edge n (visible in cycle n+1).
- Release latency: a release condition sampled at edge m clears `gnt` after edge m.
- Every handover has one mandatory bubble cycle with `gnt` = 0 (the IDLE arbitration cycle). Two consecutive grants are therefore never back-to-back.
- The mux output is valid for the owner from the cycle `gnt` rises. `sel` is stable for the whole grant, so there is no glitch on the mux select while granted.
- Fairness with all 16 requests held continuously:
  - Owners rotate 0, 1, …, 15, 0.
  - Each owner gets exactly MAX_HOLD acknowledged beats.
  - Worst-case wait for one requester is 15 grants plus 15 bubbles.

## Structure
- Shared package `mux16_sched_pkg` contains:
  - `N_REQ` = 16 and `SEL_W` = 4.
  - The state enum typedef (IDLE, GRANT).
  - A `CNT_W` = 8 constant.
- Sub-module `rr_pick16` is purely combinational.
  - Inputs: `req[15:0]` and `ptr[3:0]`.
  - Outputs: `found` (1 bit) and `idx` (4 bits).
  - Implementation: rotate right by `ptr`, find-first-set, then add `ptr` back mod 16.
- The top contains the FSM, `cnt`, `ptr`, and the output registers.
- The top does not instantiate the mux; the parent wires `sel` to `mux_16x1.si`.

## Test plan
- Reset, then `req` = 16'h0000 for 5 cycles: expect `gnt` = 0, `sel` = 0, `busy` = 0 throughout.
- Single requester:
  - Stimulus: `req` = 16'h0020 held, `ack_in` = 1 every cycle, MAX_HOLD = 8.
  - Expect `gnt` = 16'h0020 and `sel` = 5 one cycle after the request.
  - Expect release after 8 acks, one bubble cycle, then a re-grant to 5.
- All requesting:
  - Stimulus: `req` = 16'hFFFF, `ack_in` = 1.
  - Expect grant order 0, 1, …, 15, 0.
  - Expect each grant to last 8 cycles, with one `gnt` = 0 cycle between grants.
- Early drop:
  - Stimulus: owner 3 with `ack_in` = 0, then `req[3]` drops at cycle 2 of the grant while `req[9]` is pending.
  - Expect `gnt` to clear on the next edge and the next grant to go to 9, with `ptr` = 4 during that arbitration.
- Wrap and simultaneous events:
  - Stimulus: owner 15, with `req[15]` dropping in the same cycle as the final (8th) ack, and `req` = 16'h8001.
  - Expect a single release, `ptr` = 0, and the next grant to go to 0.
- Reset mid-grant:
  - Stimulus: owner 7, then `rst_n` = 0 for one cycle.
  - Expect `gnt` = 0, `sel` = 0, `busy` = 0.
  - Expect the first grant after reset to search from 0.
